// File: rtl/note_scheduler_pkg.sv
// hdr_pkg: shared types for the note scheduler.
//   cmd_e    - command codes carried in pkt[23:16]
//   pkt_t    - decoded 24-bit packet {cmd, note, dur}
//   entry_t  - FIFO payload {note, dur}
//   state_e  - sequencer FSM states
package hdr_pkg;

  typedef enum logic [7:0] {
    CMD_NOP    = 8'h00,
    CMD_PLAY   = 8'h01,
    CMD_STOP   = 8'h02,
    CMD_CLRERR = 8'h03
  } cmd_e;

  typedef struct packed {
    logic [7:0] cmd;   // kept as raw bits so unknown codes survive decoding
    logic [7:0] note;
    logic [7:0] dur;
  } pkt_t;

  typedef struct packed {
    logic [7:0] note;
    logic [7:0] dur;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_GAP
  } state_e;

  localparam int ENTRY_W = $bits(entry_t);

  function automatic logic is_known_cmd(input logic [7:0] cmd);
    return cmd <= 8'(CMD_CLRERR);
  endfunction

endpackage

// File: rtl/note_scheduler_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy and a flush.
//   clk, reset     - clock, synchronous active-low reset
//   push, din      - write request/data; accepted when not full or when
//                    a pop happens in the same cycle
//   pop, dout      - read request; dout shows the head entry (first-word
//                    fall-through); pop is ignored when empty
//   flush          - discard all entries; overrides push and pop
//   full, empty    - status from the registered count
//   count          - registered occupancy
//   count_next     - occupancy after the coming edge (for registered
//                    status derived outside the FIFO)
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     count_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  assign count_next = flush ? '0 : (count + CW'(do_push) - CW'(do_pop));

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // NOTE: storage is deliberately left out of reset; pointers and count
  // define which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/note_scheduler.sv
// note_scheduler: queues PLAY packets and sequences notes to the tone
// generator, one at a time, each followed by a fixed silent gap.
//   clk, reset     - clock, synchronous active-low reset
//   pkt_valid, pkt - one-cycle packet strobe; pkt = {cmd, note, dur}
//   tone_en        - tone generator enable (high while a note plays)
//   note           - current note index; held through gap and idle
//   busy           - sequencer active or queue non-empty
//   fifo_count     - queue occupancy
//   overflow       - sticky: a PLAY was dropped on a full queue
//   bad_cmd        - sticky: an unknown command was received
// All outputs are registered.
module note_scheduler
  import hdr_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int TICK_CYCLES = 250000,
  parameter int GAP_CYCLES  = 5000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pkt_valid,
  input  logic [23:0]            pkt,
  output logic                   tone_en,
  output logic [7:0]             note,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   bad_cmd
);

  localparam int CW = $clog2(DEPTH) + 1;
  // Duration is split into a tick prescaler and an 8-bit unit counter so
  // dur=255 at any TICK_CYCLES never needs a wide product register.
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  pkt_t p;
  assign p = pkt;

  logic cmd_play, cmd_stop, cmd_clr, cmd_bad;
  assign cmd_play = pkt_valid && (p.cmd == CMD_PLAY);
  assign cmd_stop = pkt_valid && (p.cmd == CMD_STOP);
  assign cmd_clr  = pkt_valid && (p.cmd == CMD_CLRERR);
  assign cmd_bad  = pkt_valid && !is_known_cmd(p.cmd);

  state_e        state_q, state_d;
  logic [7:0]    note_q, note_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    units_q, units_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          overflow_d, bad_cmd_d, busy_d;

  logic [ENTRY_W-1:0] head_bits;
  entry_t             head;
  logic               full, empty;
  logic [CW-1:0]      count_next;
  logic               pop;

  assign head = head_bits;

  // STOP wins over a same-cycle pop; the FIFO flush also blocks it.
  assign pop = (state_q == ST_IDLE) && !empty && !cmd_stop;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (cmd_play),
    .pop        (pop),
    .flush      (cmd_stop),
    .din        ({p.note, p.dur}),
    .dout       (head_bits),
    .full       (full),
    .empty      (empty),
    .count      (fifo_count),
    .count_next (count_next)
  );

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    presc_d = presc_q;
    units_d = units_q;
    gap_d   = gap_q;

    if (cmd_stop) begin
      state_d = ST_IDLE;
      note_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A zero-duration entry is popped and dropped: no tone, no gap,
          // and it never reaches the note output.
          if (pop && (head.dur != '0)) begin
            state_d = ST_PLAY;
            note_d  = head.note;
            presc_d = '0;
            units_d = head.dur;
          end
        end
        ST_PLAY: begin
          if (presc_q == TICK_LAST) begin
            presc_d = '0;
            units_d = units_q - 8'd1;
            if (units_q == 8'd1) begin
              state_d = ST_GAP;
              gap_d   = '0;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) state_d = ST_IDLE;
          else                   gap_d   = gap_q + GW'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Setting an error takes priority over a same-cycle clear.
    overflow_d = overflow;
    if (cmd_clr) overflow_d = 1'b0;
    if (cmd_play && full && !pop) overflow_d = 1'b1;

    bad_cmd_d = bad_cmd;
    if (cmd_clr) bad_cmd_d = 1'b0;
    if (cmd_bad) bad_cmd_d = 1'b1;

    busy_d = (state_d != ST_IDLE) || (count_next != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      note_q   <= '0;
      presc_q  <= '0;
      units_q  <= '0;
      gap_q    <= '0;
      tone_en  <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      bad_cmd  <= 1'b0;
    end else begin
      state_q  <= state_d;
      note_q   <= note_d;
      presc_q  <= presc_d;
      units_q  <= units_d;
      gap_q    <= gap_d;
      tone_en  <= (state_d == ST_PLAY);
      busy     <= busy_d;
      overflow <= overflow_d;
      bad_cmd  <= bad_cmd_d;
    end
  end

  assign note = note_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler with DEPTH=4, TICK_CYCLES=4,
// GAP_CYCLES=2. Inputs change 1 ns after a rising edge and outputs are
// sampled at that same point, so "cycle N" means the window after edge N.
module tb_note_scheduler;

  localparam int DEPTH = 4;
  localparam int TICK  = 4;
  localparam int GAP   = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pkt_valid = 1'b0;
  logic [23:0]   pkt = '0;
  logic          tone_en;
  logic [7:0]    note;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          bad_cmd;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic saw_12 = 1'b0;

  always #5 clk = ~clk;

  note_scheduler #(
    .DEPTH       (DEPTH),
    .TICK_CYCLES (TICK),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pkt_valid  (pkt_valid),
    .pkt        (pkt),
    .tone_en    (tone_en),
    .note       (note),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .bad_cmd    (bad_cmd)
  );

  // Watches for the zero-duration note ever reaching the output.
  always @(negedge clk) if (note == 8'h12) saw_12 <= 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [23:0] p);
    pkt_valid = 1'b1;
    pkt       = p;
    step(1);
    pkt_valid = 1'b0;
    pkt       = '0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_tone"},     32'(tone_en),    32'd0);
    check({tag, "_note"},     32'(note),       32'd0);
    check({tag, "_busy"},     32'(busy),       32'd0);
    check({tag, "_count"},    32'(fifo_count), 32'd0);
    check({tag, "_overflow"}, 32'(overflow),   32'd0);
    check({tag, "_bad_cmd"},  32'(bad_cmd),    32'd0);
  endtask

  // Called with tone_en already high; checks the note and the high time.
  task automatic play_len(input string tag, input logic [7:0] exp_note, input int exp_len);
    int n;
    n = 0;
    check({tag, "_note"}, 32'(note), 32'(exp_note));
    while (tone_en === 1'b1 && n < 4000) begin
      n++;
      step(1);
    end
    check({tag, "_len"}, 32'(n), 32'(exp_len));
  endtask

  task automatic low_len(input string tag, input int exp_len);
    int n;
    n = 0;
    while (tone_en === 1'b0 && n < 100) begin
      n++;
      step(1);
    end
    check({tag, "_low"}, 32'(n), 32'(exp_len));
  endtask

  initial begin
    // Reset values
    reset = 1'b0;
    step(2);
    check_quiet("reset");
    reset = 1'b1;

    // Single long note: dur=255 -> 1020 cycles high from cycle 2
    send(24'h0114ff);
    check("t1_count_c1", 32'(fifo_count), 32'd1);
    check("t1_tone_c1",  32'(tone_en),    32'd0);
    check("t1_busy_c1",  32'(busy),       32'd1);
    step(1);
    check("t1_tone_c2",  32'(tone_en),    32'd1);
    play_len("t1", 8'h14, 255 * TICK);
    check("t1_busy_gap", 32'(busy),       32'd1);
    check("t1_note_gap", 32'(note),       32'h14);
    step(GAP);
    check("t1_busy_end", 32'(busy),       32'd0);

    // Back-to-back notes: 8 high, 3 low, 4 high
    send(24'h010a02);
    send(24'h010b01);
    check("t2_tone_c2", 32'(tone_en), 32'd1);
    play_len("t2a", 8'h0a, 2 * TICK);
    low_len("t2", GAP + 1);
    play_len("t2b", 8'h0b, 1 * TICK);
    step(3);
    check("t2_busy_end", 32'(busy), 32'd0);

    // Six PLAYs during a note: queue saturates, overflow sticks, CLRERR clears
    send(24'h010102);
    step(1);
    for (int i = 0; i < 6; i++) send({8'h01, 8'(8'h20 + i), 8'h01});
    check("t3_count_full", 32'(fifo_count), 32'(DEPTH));
    check("t3_overflow",   32'(overflow),   32'd1);
    check("t3_tone",       32'(tone_en),    32'd1);
    check("t3_note",       32'(note),       32'h01);
    send(24'h030000);
    check("t3_clrerr",     32'(overflow),   32'd0);
    check("t3_count_kept", 32'(fifo_count), 32'(DEPTH));
    send(24'h020000);
    check("t3_stop_count", 32'(fifo_count), 32'd0);

    // STOP mid-note with three entries queued
    step(2);
    send(24'h013003);
    step(1);
    send(24'h013101);
    send(24'h013201);
    send(24'h013301);
    check("t4_count_pre", 32'(fifo_count), 32'd3);
    check("t4_tone_pre",  32'(tone_en),    32'd1);
    check("t4_note_pre",  32'(note),       32'h30);
    send(24'h020000);
    check("t4_tone",  32'(tone_en),    32'd0);
    check("t4_note",  32'(note),       32'd0);
    check("t4_count", 32'(fifo_count), 32'd0);
    check("t4_busy",  32'(busy),       32'd0);

    // dur=0 entry is discarded silently; next note plays normally
    step(2);
    send(24'h011200);
    send(24'h011301);
    check("t5_tone_c2", 32'(tone_en), 32'd0);
    check("t5_note_c2", 32'(note),    32'd0);
    step(1);
    check("t5_tone_c3", 32'(tone_en), 32'd1);
    play_len("t5", 8'h13, 1 * TICK);
    step(3);
    check("t5_no_12",   32'(saw_12),  32'd0);
    check("t5_busy",    32'(busy),    32'd0);

    // Unknown command, then reset mid-note
    send(24'h014002);
    send(24'h014101);
    send(24'h7f0000);
    check("t6_bad_cmd", 32'(bad_cmd),    32'd1);
    check("t6_count",   32'(fifo_count), 32'd1);
    check("t6_tone",    32'(tone_en),    32'd1);
    check("t6_note",    32'(note),       32'h40);
    check("t6_ovf",     32'(overflow),   32'd0);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    check_quiet("t6_reset");
    step(2);
    check("t6_tone_after", 32'(tone_en), 32'd0);
    check("t6_busy_after", 32'(busy),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
